eight_bit_serial_subtractor: RTL and testbench

- Bit-serial 8-bit subtractor with borrow. It computes X - Y - BorrowIn one bit per clock, LSB first.
- It is the inverse-direction companion to the team's combinational adder, for area-constrained datapaths.
- It uses a start/busy/done handshake and holds its registered result until the next operation.
- It sits beside the adder in the arithmetic unit. It also serves as the compare primitive: zero, borrow and signed-overflow flags.

---
 rtl/eight_bit_serial_subtractor_pkg.sv | 24 ++
 rtl/eight_bit_serial_subtractor_full_subtractor_bit.sv | 20 ++
 rtl/eight_bit_serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_eight_bit_serial_subtractor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/eight_bit_serial_subtractor_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eight_bit_serial_subtractor_pkg : state encoding and sizing helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package eight_bit_serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_e;

    // Counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage : eight_bit_serial_subtractor_pkg
`default_nettype wire

// File: rtl/eight_bit_serial_subtractor_full_subtractor_bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// full_subtractor_bit : one-bit full subtractor, d = x - y - bin
// Revision: 1.0
// ---------------------------------------------------------------------------
module full_subtractor_bit (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    always_comb begin
        o_d    = i_x ^ i_y ^ i_bin;
        o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);
    end

endmodule : full_subtractor_bit
`default_nettype wire

// File: rtl/eight_bit_serial_subtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eight_bit_serial_subtractor : LSB-first bit-serial X - Y - BorrowIn
// Revision: 1.0
// ---------------------------------------------------------------------------
module eight_bit_serial_subtractor
    import eight_bit_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             RCOClk,
    input  logic             RCOResetN,
    input  logic             RCOStart,
    input  logic [WIDTH-1:0] RCOSubX,
    input  logic [WIDTH-1:0] RCOSubY,
    input  logic             RCOBorrowIn,
    output logic [WIDTH-1:0] RCODiff,
    output logic             RCOBorrowOut,
    output logic             RCOOverflow,
    output logic             RCOZero,
    output logic             RCOBusy,
    output logic             RCODone
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] COMMIT   = CNT_W'(WIDTH);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d, diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             x_msb_q, x_msb_d, y_msb_q, y_msb_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             w_bit_d, w_bit_bout;

    full_subtractor_bit u_fs (
        .i_x    (x_q[0]),
        .i_y    (y_q[0]),
        .i_bin  (borrow_q),
        .o_d    (w_bit_d),
        .o_bout (w_bit_bout)
    );

    always_ff @(posedge RCOClk or negedge RCOResetN) begin
        if (!RCOResetN) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            x_msb_q  <= 1'b0;
            y_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            x_msb_q  <= x_msb_d;
            y_msb_q  <= y_msb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        x_msb_d  = x_msb_q;
        y_msb_d  = y_msb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (RCOStart) begin
                    x_d      = RCOSubX;
                    y_d      = RCOSubY;
                    borrow_d = RCOBorrowIn;
                    x_msb_d  = RCOSubX[WIDTH-1];
                    y_msb_d  = RCOSubY[WIDTH-1];
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == COMMIT) begin
                    // All bits are in: publish the result and flags together.
                    diff_d  = res_q;
                    bout_d  = borrow_q;
                    ovf_d   = (x_msb_q ^ y_msb_q) & (res_q[WIDTH-1] ^ x_msb_q);
                    zero_d  = (res_q == '0);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    res_d    = {w_bit_d, res_q[WIDTH-1:1]};
                    borrow_d = w_bit_bout;
                    x_d      = x_q >> 1;
                    y_d      = y_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        busy_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign RCODiff      = diff_q;
    assign RCOBorrowOut = bout_q;
    assign RCOOverflow  = ovf_q;
    assign RCOZero      = zero_q;
    assign RCOBusy      = busy_q;
    assign RCODone      = done_q;

endmodule : eight_bit_serial_subtractor
`default_nettype wire

// File: tb/tb_eight_bit_serial_subtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_eight_bit_serial_subtractor : scoreboard bench for the serial subtractor
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_eight_bit_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] sub_x, sub_y;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout, ovf, zero, busy, done;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        logic             zero;
    } exp_t;

    exp_t sb[$];

    eight_bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .RCOClk       (clk),
        .RCOResetN    (rst_n),
        .RCOStart     (start),
        .RCOSubX      (sub_x),
        .RCOSubY      (sub_y),
        .RCOBorrowIn  (bin),
        .RCODiff      (diff),
        .RCOBorrowOut (bout),
        .RCOOverflow  (ovf),
        .RCOZero      (zero),
        .RCOBusy      (busy),
        .RCODone      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic b);
        exp_t        e;
        logic [WIDTH:0] r;
        r      = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, b};
        e.diff = r[WIDTH-1:0];
        e.bout = r[WIDTH];
        e.ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        e.zero = (r[WIDTH-1:0] == '0);
        return e;
    endfunction

    // Scoreboard consumer: every Done must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                check_val("done_without_op", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("diff", 32'(diff), 32'(e.diff));
                check_val("borrow_out", 32'(bout), 32'(e.bout));
                check_val("overflow", 32'(ovf), 32'(e.ovf));
                check_val("zero", 32'(zero), 32'(e.zero));
            end
        end
    end

    // Counts edges until Done is seen #1 after an edge; bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 30);
        if (!done) check_val("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic b, input bit chk_timing);
        int n;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        sub_x = x;
        sub_y = y;
        bin   = b;
        sb.push_back(model(x, y, b));
        @(posedge clk);
        #1;
        start    = 1'b0;
        sub_x    = WIDTH'($urandom);
        sub_y    = WIDTH'($urandom);
        bin      = 1'($urandom);
        busy_cnt = busy ? 1 : 0;
        n        = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (busy) busy_cnt++;
        end
        if (chk_timing) begin
            check_val("latency", 32'(n), 32'd9);
            check_val("busy_cycles", 32'(busy_cnt), 32'd8);
        end else if (!done) begin
            check_val("done_timeout", 32'(done), 32'd1);
        end
    endtask

    initial begin
        int n;
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        sub_x = '0;
        sub_y = '0;
        bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_diff", 32'(diff), 32'd0);
        check_val("rst_flags", {28'd0, bout, ovf, zero, busy}, 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h50, 8'h20, 1'b0, 1'b1);
        run_op(8'h20, 8'h50, 1'b0, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 1'b1);
        run_op(8'h80, 8'h01, 1'b0, 1'b1);
        run_op(8'h5A, 8'h5A, 1'b0, 1'b1);

        // Result must hold while idle.
        repeat (10) @(posedge clk);
        #1;
        check_val("hold_diff", 32'(diff), 32'h00);
        check_val("hold_zero", 32'(zero), 32'd1);
        check_val("hold_done_low", 32'(done), 32'd0);

        // Start pulse during SHIFT is ignored.
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1;
        sub_x = 8'h10;
        sub_y = 8'h01;
        bin   = 1'b0;
        sb.push_back(model(8'h10, 8'h01, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        sub_x = 8'hFF;
        sub_y = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check_val("ignored_start_latency", 32'(n), 32'd5);
        check_val("ignored_diff", 32'(diff), 32'h0F);
        // Start held during the Done cycle: accepted back to back.
        run_op(8'h33, 8'h44, 1'b1, 1'b1);
        repeat (12) @(posedge clk);
        check_val("done_pulses", 32'(done_seen - d0), 32'd2);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1;
        sub_x = 8'h77;
        sub_y = 8'h11;
        bin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_diff", 32'(diff), 32'd0);
        check_val("abort_flags", {28'd0, bout, ovf, zero, busy}, 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        d0 = done_seen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        check_val("abort_no_done", 32'(done_seen - d0), 32'd0);
        run_op(8'h03, 8'h01, 1'b0, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        end

        repeat (3) @(posedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_eight_bit_serial_subtractor
`default_nettype wire
